// File: rtl/four_phase_tx_pkg.sv
// Shared definitions for the 4-phase bundled-data sender: FSM encodings and counter width.
package four_phase_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

endpackage

// File: rtl/four_phase_tx_if.sv
// Upstream valid/ready port plus the req/ack/data bundled-data channel.
interface four_phase_tx_if #(
    parameter int unsigned DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              ch_req;
    logic [DATA_W-1:0] ch_data;
    logic              ch_ack;

    // master: the sending bridge; slave: upstream producer and channel receiver
    modport master (
        input  in_valid, in_data, ch_ack,
        output in_ready, ch_req, ch_data
    );
    modport slave (
        output in_valid, in_data, ch_ack,
        input  in_ready, ch_req, ch_data
    );
endinterface

// File: rtl/four_phase_tx_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, cleared to 0 by reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/four_phase_tx.sv
// Clocked valid/ready to 4-phase return-to-zero bundled-data sender.
// All channel outputs come from flops; ch_ack is only ever seen through the synchronizer.
module four_phase_tx
    import four_phase_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    four_phase_tx_if.master  bus,
    input  logic             err_clr,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] tx_count
);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(TIMEOUT - 1);

    logic              ack_s;
    logic              sync_primed;
    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [DATA_W-1:0] ch_data_q,  ch_data_d;
    logic              ch_req_q,   ch_req_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.ch_ack),
        .q_o   (ack_s)
    );

    // ack_s reads 0 until the chain has filled after reset, so hold off in_ready until it has
    sync_ff #(.STAGES(SYNC_STAGES)) u_prime_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (1'b1),
        .q_o   (sync_primed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_cnt_q   <= '0;
            ch_data_q  <= '0;
            ch_req_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            ch_data_q  <= ch_data_d;
            ch_req_q   <= ch_req_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_data_d = ch_data_q;
        tx_cnt_d  = tx_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    ch_data_d = bus.in_data;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (ack_s) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == PHASE_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    state_d  = ST_IDLE;
                end else if (cnt_q == PHASE_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr && !ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Phase counter restarts on every state change and saturates while a state is held
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        ch_req_d   = (state_d == ST_WAIT_HI);
        in_ready_d = (state_d == ST_IDLE) && !ack_s && sync_primed;
        busy_d     = (state_d != ST_IDLE);
        err_d      = (state_d == ST_ERR);
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ch_req   = ch_req_q;
    assign bus.ch_data  = ch_data_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;
    assign tx_count     = tx_cnt_q;

endmodule
